// File: rtl/hostadapter_pkg.sv
// rtl/hostadapter_pkg.sv - shared constants and types for the synchronous SCSI host adapter
// Holds register indices, handshake FSM states, IRQ and status bit positions,
// and the level saturation helper used by the level register.
package hostadapter_pkg;

  // Host register indices
  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_SEL    = 3'd2;
  localparam logic [2:0] REG_MASK   = 3'd3;
  localparam logic [2:0] REG_CFG    = 3'd4;
  localparam logic [2:0] REG_LEVEL  = 3'd5;
  localparam logic [2:0] REG_CFGRD  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OSETUP,
    ST_OACK,
    ST_IACK,
    ST_WREL
  } hs_state_e;

  // Interrupt pending bit positions
  localparam int IRQ_CMD  = 0;
  localparam int IRQ_RXNE = 1;
  localparam int IRQ_TXE  = 2;
  localparam int IRQ_ERR  = 3;

  // Status register bit positions
  localparam int STAT_MSG   = 0;
  localparam int STAT_BSY   = 1;
  localparam int STAT_SELTO = 2;
  localparam int STAT_ERR   = 3;
  localparam int STAT_IRQ   = 4;
  localparam int STAT_REQ   = 5;
  localparam int STAT_IO    = 6;
  localparam int STAT_CND   = 7;

  // FIFO levels reach 64, but the level register only has four bits per FIFO
  function automatic logic [3:0] sat4(input logic [6:0] lvl);
    return (lvl > 7'd15) ? 4'hF : lvl[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - 8-bit synchronous FIFO with first-word fall-through read
// Ports: clk, rst (sync, active-high), flush (empties the FIFO),
//        push/wdata, pop/rdata, full, empty, level (0..DEPTH).
// Push while full and pop while empty are ignored; flush overrides both.
module sync_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == LW'(DEPTH));
  assign empty = (count_q == '0);
  assign level = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push & ~full & ~flush;
    pop_ok   = pop & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      // Simultaneous push and pop leaves the level unchanged
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + LW'(1);
        2'b01:   count_d = count_q - LW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/scsi_host_adapter_sync.sv
// rtl/scsi_host_adapter_sync.sv - synchronous SCSI host adapter: registers, FIFOs, REQ/ACK engine, IRQ
// Host side: bbc_STB/bbc_RnW/bbc_ADDR/bbc_WDATA strobed access, bbc_RDATA one cycle later, bbc_IRQ.
// SCSI side: scsi_SEL/ACK/DOE/DOUT/CONF outputs, scsi_DIN and REQ/BSY/MSG/CnD/IO inputs.
// Optional macro HOSTADAPTER_PARITY_EN adds scsi_DOUTP (odd parity out), scsi_DINP
// (parity in) and scsi_PERR (sticky inbound parity error, also folded into err).
module scsi_host_adapter_sync #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SETUP_CYC   = 2,
  parameter int SEL_TIMEOUT = 65535
) (
  input  logic       sys_CLK,
  input  logic       sys_RST,
  input  logic       bbc_STB,
  input  logic       bbc_RnW,
  input  logic [2:0] bbc_ADDR,
  input  logic [7:0] bbc_WDATA,
  output logic [7:0] bbc_RDATA,
  output logic       bbc_IRQ,
  output logic       scsi_CONF,
  output logic       scsi_SEL,
  output logic       scsi_ACK,
  output logic       scsi_DOE,
  output logic [7:0] scsi_DOUT,
  input  logic [7:0] scsi_DIN,
  input  logic       scsi_REQ,
  input  logic       scsi_BSY,
  input  logic       scsi_MSG,
  input  logic       scsi_CnD,
  input  logic       scsi_IO
`ifdef HOSTADAPTER_PARITY_EN
  ,
  output logic       scsi_DOUTP,
  input  logic       scsi_DINP,
  output logic       scsi_PERR
`endif
);
  import hostadapter_pkg::*;

  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam int SW    = (SETUP_CYC < 2) ? 1 : $clog2(SETUP_CYC);
  localparam int SEL_W = (SEL_TIMEOUT < 2) ? 1 : $clog2(SEL_TIMEOUT);

  hs_state_e  state_q, state_d;
  logic [SW-1:0]    setup_cnt_q, setup_cnt_d;
  logic [SEL_W-1:0] sel_cnt_q, sel_cnt_d;
  logic       ack_q, ack_d, doe_q, doe_d, sel_q, sel_d, conf_q, conf_d;
  logic       err_q, err_d, sel_to_q, sel_to_d, irq_q, irq_d, bsy_q;
  logic [7:0] dout_q, dout_d, rdata_q, rdata_d, cfg_q, cfg_d;
  logic [3:0] mask_q, mask_d, pending;
  logic [7:0] status;

  logic       wr_stb, rd_stb;
  logic       tx_push, tx_pop, rx_push, rx_pop, flush;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0] tx_rdata, rx_rdata;
  logic [LW-1:0] tx_level, rx_level;

`ifdef HOSTADAPTER_PARITY_EN
  logic perr_q, perr_d, par_err;
  assign scsi_DOUTP = ~^dout_q;
  assign scsi_PERR  = perr_q;
`endif

  sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(sys_CLK), .rst(sys_RST), .flush(flush),
    .push(tx_push), .wdata(bbc_WDATA), .pop(tx_pop), .rdata(tx_rdata),
    .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(sys_CLK), .rst(sys_RST), .flush(flush),
    .push(rx_push), .wdata(scsi_DIN), .pop(rx_pop), .rdata(rx_rdata),
    .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  assign wr_stb = bbc_STB & ~bbc_RnW;
  assign rd_stb = bbc_STB & bbc_RnW;

  always_comb begin
    status            = '0;
    status[STAT_CND]  = scsi_CnD;
    status[STAT_IO]   = scsi_IO;
    status[STAT_REQ]  = scsi_REQ;
    status[STAT_IRQ]  = irq_q;
    status[STAT_ERR]  = err_q;
    status[STAT_SELTO]= sel_to_q;
    status[STAT_BSY]  = scsi_BSY;
    status[STAT_MSG]  = scsi_MSG;

    pending           = '0;
    pending[IRQ_CMD]  = scsi_REQ & scsi_CnD;
    pending[IRQ_RXNE] = ~rx_empty;
    pending[IRQ_TXE]  = tx_empty & scsi_REQ & ~scsi_IO;
    pending[IRQ_ERR]  = err_q | sel_to_q;
  end

  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    ack_d       = ack_q;
    doe_d       = doe_q;
    dout_d      = dout_q;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    flush       = 1'b0;
`ifdef HOSTADAPTER_PARITY_EN
    par_err     = 1'b0;
`endif

    // Target releasing BSY mid-byte abandons the transfer and all buffered data
    if (bsy_q && !scsi_BSY && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      ack_d   = 1'b0;
      doe_d   = 1'b0;
      flush   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (scsi_REQ && !scsi_IO && !tx_empty) begin
            tx_pop      = 1'b1;
            dout_d      = tx_rdata;
            doe_d       = 1'b1;
            setup_cnt_d = '0;
            state_d     = ST_OSETUP;
          end else if (scsi_REQ && scsi_IO && !rx_full) begin
            rx_push = 1'b1;
            ack_d   = 1'b1;
            state_d = ST_IACK;
`ifdef HOSTADAPTER_PARITY_EN
            par_err = ~^{scsi_DIN, scsi_DINP};
`endif
          end
        end
        ST_OSETUP: begin
          if (setup_cnt_q == SW'(SETUP_CYC - 1)) begin
            ack_d   = 1'b1;
            state_d = ST_OACK;
          end else begin
            setup_cnt_d = setup_cnt_q + SW'(1);
          end
        end
        // IO is ignored here so a direction change only affects the next byte
        ST_OACK, ST_IACK: begin
          if (!scsi_REQ) begin
            ack_d   = 1'b0;
            state_d = ST_WREL;
          end
        end
        ST_WREL: begin
          doe_d   = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    tx_push = wr_stb && (bbc_ADDR == REG_DATA);
    rx_pop  = rd_stb && (bbc_ADDR == REG_DATA);

    // Status read clears the sticky flags; a fresh error in the same cycle wins
    err_d    = err_q;
    sel_to_d = sel_to_q;
    if (rd_stb && bbc_ADDR == REG_STATUS) begin
      err_d    = 1'b0;
      sel_to_d = 1'b0;
    end
    if (tx_push && tx_full)  err_d = 1'b1;
    if (rx_pop  && rx_empty) err_d = 1'b1;
`ifdef HOSTADAPTER_PARITY_EN
    perr_d = perr_q;
    if (rd_stb && bbc_ADDR == REG_STATUS) perr_d = 1'b0;
    if (par_err) begin
      perr_d = 1'b1;
      err_d  = 1'b1;
    end
`endif

    sel_d     = sel_q;
    sel_cnt_d = sel_cnt_q;
    if (sel_q) begin
      if (scsi_BSY) begin
        sel_d = 1'b0;
      end else if (SEL_TIMEOUT != 0) begin
        if (sel_cnt_q == SEL_W'(SEL_TIMEOUT - 1)) begin
          sel_d    = 1'b0;
          sel_to_d = 1'b1;
        end else begin
          sel_cnt_d = sel_cnt_q + SEL_W'(1);
        end
      end
    end
    if (wr_stb && bbc_ADDR == REG_SEL && !scsi_BSY) begin
      sel_d     = 1'b1;
      sel_cnt_d = '0;
    end

    mask_d = mask_q;
    if (wr_stb && bbc_ADDR == REG_MASK) mask_d = bbc_WDATA[3:0];

    conf_d = wr_stb && (bbc_ADDR == REG_CFG);
    cfg_d  = conf_d ? bbc_WDATA : cfg_q;

    rdata_d = rdata_q;
    if (rd_stb) begin
      case (bbc_ADDR)
        REG_DATA:   rdata_d = rx_empty ? 8'h00 : rx_rdata;
        REG_STATUS: rdata_d = status;
        REG_LEVEL:  rdata_d = {sat4(7'(tx_level)), sat4(7'(rx_level))};
        REG_CFGRD:  rdata_d = cfg_q;
        default:    rdata_d = 8'h00;
      endcase
    end

    irq_d = |(pending & mask_q);
  end

  always_ff @(posedge sys_CLK) begin
    if (sys_RST) begin
      state_q     <= ST_IDLE;
      setup_cnt_q <= '0;
      sel_cnt_q   <= '0;
      ack_q       <= 1'b0;
      doe_q       <= 1'b0;
      sel_q       <= 1'b0;
      conf_q      <= 1'b0;
      err_q       <= 1'b0;
      sel_to_q    <= 1'b0;
      irq_q       <= 1'b0;
      bsy_q       <= 1'b0;
      dout_q      <= '0;
      rdata_q     <= '0;
      cfg_q       <= '0;
      mask_q      <= '0;
`ifdef HOSTADAPTER_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      sel_cnt_q   <= sel_cnt_d;
      ack_q       <= ack_d;
      doe_q       <= doe_d;
      sel_q       <= sel_d;
      conf_q      <= conf_d;
      err_q       <= err_d;
      sel_to_q    <= sel_to_d;
      irq_q       <= irq_d;
      bsy_q       <= scsi_BSY;
      dout_q      <= dout_d;
      rdata_q     <= rdata_d;
      cfg_q       <= cfg_d;
      mask_q      <= mask_d;
`ifdef HOSTADAPTER_PARITY_EN
      perr_q      <= perr_d;
`endif
    end
  end

  assign bbc_RDATA = rdata_q;
  assign bbc_IRQ   = irq_q;
  assign scsi_CONF = conf_q;
  assign scsi_SEL  = sel_q;
  assign scsi_ACK  = ack_q;
  assign scsi_DOE  = doe_q;
  assign scsi_DOUT = dout_q;

endmodule

// File: tb/tb_scsi_host_adapter_sync.sv
// tb/tb_scsi_host_adapter_sync.sv - directed self-checking bench for scsi_host_adapter_sync
module tb_scsi_host_adapter_sync;

  logic       sys_CLK = 1'b0;
  logic       sys_RST = 1'b1;
  logic       bbc_STB = 1'b0;
  logic       bbc_RnW = 1'b0;
  logic [2:0] bbc_ADDR = '0;
  logic [7:0] bbc_WDATA = '0;
  logic [7:0] bbc_RDATA;
  logic       bbc_IRQ, scsi_CONF, scsi_SEL, scsi_ACK, scsi_DOE;
  logic [7:0] scsi_DOUT;
  logic [7:0] scsi_DIN = '0;
  logic       scsi_REQ = 1'b0, scsi_BSY = 1'b0, scsi_MSG = 1'b0;
  logic       scsi_CnD = 1'b0, scsi_IO = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] rd;

  scsi_host_adapter_sync #(
    .FIFO_DEPTH(8), .SETUP_CYC(2), .SEL_TIMEOUT(20)
  ) dut (
    .sys_CLK(sys_CLK), .sys_RST(sys_RST),
    .bbc_STB(bbc_STB), .bbc_RnW(bbc_RnW), .bbc_ADDR(bbc_ADDR),
    .bbc_WDATA(bbc_WDATA), .bbc_RDATA(bbc_RDATA), .bbc_IRQ(bbc_IRQ),
    .scsi_CONF(scsi_CONF), .scsi_SEL(scsi_SEL), .scsi_ACK(scsi_ACK),
    .scsi_DOE(scsi_DOE), .scsi_DOUT(scsi_DOUT), .scsi_DIN(scsi_DIN),
    .scsi_REQ(scsi_REQ), .scsi_BSY(scsi_BSY), .scsi_MSG(scsi_MSG),
    .scsi_CnD(scsi_CnD), .scsi_IO(scsi_IO)
  );

  always #5 sys_CLK = ~sys_CLK;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge sys_CLK);
  endtask

  task automatic host_wr(input logic [2:0] a, input logic [7:0] d);
    bbc_STB = 1'b1; bbc_RnW = 1'b0; bbc_ADDR = a; bbc_WDATA = d;
    tick();
    bbc_STB = 1'b0;
  endtask

  task automatic host_rd(input logic [2:0] a, output logic [7:0] d);
    bbc_STB = 1'b1; bbc_RnW = 1'b1; bbc_ADDR = a;
    tick();
    bbc_STB = 1'b0;
    d = bbc_RDATA;
  endtask

  initial begin
    tick(3);
    sys_RST = 1'b0;
    expect_eq("reset_outputs", {bbc_RDATA, scsi_DOUT, bbc_IRQ, scsi_CONF, scsi_SEL, scsi_ACK, scsi_DOE}, 0);
    host_rd(3'd1, rd); expect_eq("reset_status", rd, 8'h00);
    expect_eq("reset_irq", bbc_IRQ, 0);
    host_rd(3'd5, rd); expect_eq("reset_level", rd, 8'h00);

    // Config write pulses CONF and is readable back
    host_wr(3'd4, 8'h5A); expect_eq("conf_pulse", scsi_CONF, 1);
    tick();               expect_eq("conf_clear", scsi_CONF, 0);
    host_rd(3'd6, rd);    expect_eq("cfg_read", rd, 8'h5A);
    host_rd(3'd7, rd);    expect_eq("unmapped_read", rd, 8'h00);

    // Outbound byte
    host_wr(3'd0, 8'hA5);
    scsi_IO = 1'b0; scsi_REQ = 1'b1;
    tick(); expect_eq("out_dout_doe", {scsi_DOUT, scsi_DOE, scsi_ACK}, {8'hA5, 1'b1, 1'b0});
    tick(); expect_eq("out_ack_setup", scsi_ACK, 0);
    tick(); expect_eq("out_ack_rise", scsi_ACK, 1);
    scsi_REQ = 1'b0;
    tick(); expect_eq("out_ack_fall", {scsi_ACK, scsi_DOE}, 2'b01);
    tick(); expect_eq("out_doe_fall", scsi_DOE, 0);
    host_rd(3'd5, rd); expect_eq("out_level", rd, 8'h00);

    // Inbound byte with RX-not-empty interrupt
    host_wr(3'd3, 8'h02);
    scsi_IO = 1'b1; scsi_DIN = 8'h3C; scsi_REQ = 1'b1;
    tick(); expect_eq("in_ack", scsi_ACK, 1);
    tick(); expect_eq("in_irq", bbc_IRQ, 1);
    scsi_REQ = 1'b0;
    tick(2); expect_eq("in_ack_fall", scsi_ACK, 0);
    host_rd(3'd0, rd); expect_eq("in_data", rd, 8'h3C);
    tick(); expect_eq("in_irq_clear", bbc_IRQ, 0);
    scsi_IO = 1'b0;

    // Selection timeout
    host_wr(3'd3, 8'h08);
    host_wr(3'd2, 8'h00); expect_eq("sel_set", scsi_SEL, 1);
    tick(19); expect_eq("sel_held", scsi_SEL, 1);
    tick();   expect_eq("sel_timeout", scsi_SEL, 0);
    tick();   expect_eq("selto_irq", bbc_IRQ, 1);
    host_rd(3'd1, rd); expect_eq("selto_status", rd, 8'h14);
    tick();   expect_eq("selto_irq_clear", bbc_IRQ, 0);

    // SEL ignored while BSY, cleared once BSY arrives
    scsi_BSY = 1'b1;
    host_wr(3'd2, 8'h00); expect_eq("sel_ignored_bsy", scsi_SEL, 0);
    scsi_BSY = 1'b0;
    host_wr(3'd2, 8'h00); expect_eq("sel_set2", scsi_SEL, 1);
    scsi_BSY = 1'b1;
    tick(); expect_eq("sel_bsy_clear", scsi_SEL, 0);

    // Underflow, overflow, then BSY drop mid-handshake
    host_wr(3'd3, 8'h00);
    host_rd(3'd0, rd); expect_eq("underflow_data", rd, 8'h00);
    host_rd(3'd1, rd); expect_eq("underflow_err", rd, 8'h0A);
    for (int i = 0; i < 9; i++) host_wr(3'd0, 8'hD0 + 8'(i));
    host_rd(3'd5, rd); expect_eq("full_level", rd, 8'h80);
    host_rd(3'd1, rd); expect_eq("overflow_err", rd, 8'h0A);
    host_rd(3'd1, rd); expect_eq("err_cleared", rd, 8'h02);
    scsi_IO = 1'b1; scsi_DIN = 8'h77; scsi_REQ = 1'b1;
    tick(); scsi_REQ = 1'b0;
    tick(2);
    host_rd(3'd5, rd); expect_eq("both_level", rd, 8'h81);
    scsi_IO = 1'b0; scsi_REQ = 1'b1;
    tick(); expect_eq("abort_pre_dout", {scsi_DOUT, scsi_DOE}, {8'hD0, 1'b1});
    tick(2); expect_eq("abort_pre_ack", scsi_ACK, 1);
    scsi_BSY = 1'b0;
    tick(); expect_eq("abort_ack_doe", {scsi_ACK, scsi_DOE}, 2'b00);
    scsi_REQ = 1'b0;
    host_rd(3'd5, rd); expect_eq("abort_level", rd, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
